clock_enable_bank: RTL and testbench

- Multi-channel, run-time programmable clock-enable generator; successor to the single fixed-divisor CE divider.
- Each channel divides clk_in by its own loadable divisor and produces a one-cycle CE pulse.
- Each channel runs in periodic or one-shot mode and has start/stop control.
- Sits between the top-level clock and the pendulum timing and display logic, which consume CE_out as synchronous enables rather than derived clocks.

---
 rtl/clock_enable_bank.sv | 111 +++++++++++
 tb/tb_clock_enable_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_bank.sv
// Multi-channel programmable clock-enable generator with per-channel divisor, mode and run control.
// Optional CE_COUNT_EN adds cnt_clr and per-channel 16-bit saturating CE counters (ce_count).
module clock_enable_bank #(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 32,
    parameter int DEFAULT_DIV = 10,
    parameter int CH_IDX_W    = 2
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [CH_IDX_W-1:0]  cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    input  logic                 cfg_mode,
    input  logic [NUM_CH-1:0]    run,
`ifdef CE_COUNT_EN
    input  logic                 cnt_clr,
    output logic [NUM_CH*16-1:0] ce_count,
`endif
    output logic [NUM_CH-1:0]    CE_out,
    output logic [NUM_CH-1:0]    busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] DEF = CNT_WIDTH'(DEFAULT_DIV);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t               state;
        state_t               state_nxt;
        logic [CNT_WIDTH-1:0] count;
        logic [CNT_WIDTH-1:0] div_active;
        logic [CNT_WIDTH-1:0] div_shadow;
        logic [CNT_WIDTH-1:0] shadow_nxt;
        logic [CNT_WIDTH-1:0] d_eff;
        logic                 mode;
        logic                 wr;
        logic                 ce;
        logic                 bsy;

        // channel index match; out-of-range selects never match
        assign wr         = cfg_we && (cfg_ch == CH_IDX_W'(i));
        assign shadow_nxt = wr ? cfg_div : div_shadow;
        assign d_eff      = (div_active == '0) ? ONE : div_active;

        // state register
        always_ff @(posedge clk_in) begin
            if (!reset_n) state <= S_IDLE;
            else          state <= state_nxt;
        end

        // next-state decode; run low wins over a coincident CE
        always_comb begin
            state_nxt = state;
            unique case (state)
                S_IDLE: if (run[i]) state_nxt = S_RUN;
                S_RUN: begin
                    if (!run[i])        state_nxt = S_IDLE;
                    else if (ce && mode) state_nxt = S_DONE;
                end
                S_DONE: if (!run[i]) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end

        // outputs decoded from registered state and count
        always_comb begin
            ce  = (state == S_RUN) && (count == d_eff - ONE);
            bsy = (state == S_RUN);
        end

        // counter, divisor shadow/active and mode registers
        always_ff @(posedge clk_in) begin
            if (!reset_n) begin
                count      <= '0;
                div_active <= DEF;
                div_shadow <= DEF;
                mode       <= 1'b0;
            end else begin
                if (wr) begin
                    div_shadow <= cfg_div;
                    mode       <= cfg_mode;
                end
                if (state != S_RUN || ce) div_active <= shadow_nxt;
                if (state == S_RUN && run[i] && !ce) count <= count + ONE;
                else                                 count <= '0;
            end
        end

        assign CE_out[i] = ce;
        assign busy[i]   = bsy;

`ifdef CE_COUNT_EN
        logic [15:0] cnt;

        // saturating CE pulse counter, clear has priority
        always_ff @(posedge clk_in) begin
            if (!reset_n || cnt_clr)        cnt <= 16'd0;
            else if (ce && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
        end

        assign ce_count[16*i +: 16] = cnt;
`endif
    end

endmodule

// File: tb/tb_clock_enable_bank.sv
// Randomized self-checking bench for clock_enable_bank against a cycle-index reference model.
// Counter checks are compiled in when CE_COUNT_EN is defined.
module tb_clock_enable_bank;

    localparam int N = 4;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [31:0] cfg_div;
    logic        cfg_mode;
    logic [N-1:0] run;
    logic [N-1:0] CE_out;
    logic [N-1:0] busy;
`ifdef CE_COUNT_EN
    logic         cnt_clr;
    logic [N*16-1:0] ce_count;
`endif

    clock_enable_bank #(
        .NUM_CH(N), .CNT_WIDTH(32), .DEFAULT_DIV(10), .CH_IDX_W(3)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_mode(cfg_mode),
        .run     (run),
`ifdef CE_COUNT_EN
        .cnt_clr (cnt_clr),
        .ce_count(ce_count),
`endif
        .CE_out  (CE_out),
        .busy    (busy)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // reference model: a running channel knows the absolute cycle of its next pulse
    bit          m_act[N];
    bit          m_done[N];
    longint      m_due[N];
    logic [31:0] m_shadow[N];
    bit          m_mode[N];
    int          m_cnt[N];
    longint      cyc = 0;
    logic [N-1:0] cur_run = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic longint eff(input logic [31:0] d);
        return (d == 32'd0) ? 64'sd1 : longint'(d);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_done[i] = 0; m_due[i] = 0;
            m_shadow[i] = 32'd10; m_mode[i] = 0; m_cnt[i] = 0;
        end
    endtask

    function automatic bit exp_ce(input int i);
        return m_act[i] && (cyc == m_due[i]);
    endfunction

    task automatic step(input logic [N-1:0] rn, input logic we, input logic [2:0] ch,
                        input logic [31:0] dv, input logic md, input logic rst,
                        input logic clr);
        logic [N-1:0] e_ce;
        logic [N-1:0] e_bsy;
        bit ce;
        bit wr;
        logic [31:0] sh;
        @(negedge clk_in);
        for (int i = 0; i < N; i++) begin
            e_ce[i]  = exp_ce(i);
            e_bsy[i] = m_act[i];
        end
        chk("ce_out", 32'(CE_out), 32'(e_ce));
        chk("busy", 32'(busy), 32'(e_bsy));
`ifdef CE_COUNT_EN
        for (int i = 0; i < N; i++)
            chk("ce_count", 32'(ce_count[16*i +: 16]), 32'(m_cnt[i]));
        cnt_clr = clr;
`endif
        run = rn; cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_mode = md;
        reset_n = !rst;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                ce = exp_ce(i);
                wr = we && (int'(ch) == i);
                sh = wr ? dv : m_shadow[i];
                if (clr) m_cnt[i] = 0;
                else if (ce && m_cnt[i] < 65535) m_cnt[i]++;
                if (m_act[i]) begin
                    if (!rn[i]) m_act[i] = 0;
                    else if (ce && m_mode[i]) begin
                        m_act[i] = 0; m_done[i] = 1;
                    end else if (ce) m_due[i] = cyc + eff(sh);
                end else if (m_done[i]) begin
                    if (!rn[i]) m_done[i] = 0;
                end else if (rn[i]) begin
                    m_act[i] = 1;
                    m_due[i] = cyc + eff(sh);
                end
                m_shadow[i] = sh;
                if (wr) m_mode[i] = md;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(cur_run, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_cfg(input logic [2:0] ch, input logic [31:0] dv, input logic md);
        step(cur_run, 1, ch, dv, md, 0, 0);
    endtask

    initial begin
        bit done;
        reset_n = 0; cfg_we = 0; cfg_ch = 0; cfg_div = 0; cfg_mode = 0; run = '0;
`ifdef CE_COUNT_EN
        cnt_clr = 0;
`endif
        model_reset();
        repeat (2) @(posedge clk_in);
        idle(3);

        cur_run[0] = 1; idle(25);

        wr_cfg(1, 3, 0);
        cur_run[1] = 1; idle(10);
        wr_cfg(1, 5, 0); idle(15);

        wr_cfg(2, 4, 1);
        cur_run[2] = 1; idle(12);
        cur_run[2] = 0; idle(2);
        cur_run[2] = 1; idle(8);

        wr_cfg(3, 0, 0);
        cur_run[3] = 1; idle(5);
        wr_cfg(3, 1, 0); idle(5);
        wr_cfg(3, 6, 0); idle(3);
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (m_act[3] && cyc == m_due[3]) begin
                cur_run[3] = 0; idle(1); done = 1;
            end else idle(1);
        end
        chk("ch3_drop_seen", 32'(done), 32'd1);
        idle(3);

        cur_run = '1; idle(7);
        step(cur_run, 0, 0, 0, 0, 1, 0);
        idle(25);
        wr_cfg(4, 2, 1);
        wr_cfg(7, 1, 1);
        idle(25);

        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] rn;
            logic we;
            logic [31:0] dv;
            rn = cur_run;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 29) == 0) rn[i] = ~rn[i];
            cur_run = rn;
            we = ($urandom_range(0, 5) == 0);
            dv = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 7));
            step(cur_run, we, 3'($urandom_range(0, 7)), dv, 1'($urandom),
                 $urandom_range(0, 399) == 0, 0);
        end

`ifdef CE_COUNT_EN
        cur_run = '0;
        step(cur_run, 0, 0, 0, 0, 1, 0);
        wr_cfg(0, 1, 0);
        cur_run[0] = 1; idle(70000);
        chk("sat", 32'(ce_count[15:0]), 32'h0000FFFF);
        step(cur_run, 0, 0, 0, 0, 0, 1);
        idle(5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
